// File: rtl/spi_reg_decoder.sv
// SPI mode-0 slave bridged onto a single-cycle register read/write bus.
// Define SPI_REG_DECODER_BURST_EN for auto-incrementing burst frames.
module spi_reg_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] IGN  = 2'd3;

  logic [1:0] sclk_q, cs_q, mosi_q;
  logic       sclk_h_q, cs_h_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q   <= 2'b00;
      cs_q     <= 2'b11;
      mosi_q   <= 2'b00;
      sclk_h_q <= 1'b0;
      cs_h_q   <= 1'b1;
    end else begin
      sclk_q   <= {sclk_q[0], sclk};
      cs_q     <= {cs_q[0], cs_n};
      mosi_q   <= {mosi_q[0], mosi};
      sclk_h_q <= sclk_q[1];
      cs_h_q   <= cs_q[1];
    end
  end

  logic sclk_rise, sclk_fall, cs_fall;
  assign sclk_rise = sclk_q[1] & ~sclk_h_q;
  assign sclk_fall = ~sclk_q[1] & sclk_h_q;
  assign cs_fall   = ~cs_q[1] & cs_h_q;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] sin_q, sin_d;
  logic [7:0] sout_q, sout_d;
  logic       rw_q, rw_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] dw_q, dw_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [7:0] rx_byte;

  assign rx_byte = {sin_q, mosi_q[1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sin_d   = sin_q;
    sout_d  = sout_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    dw_d    = dw_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    // read data is sampled in the strobe cycle itself
    if (rd_q) sout_d = data_read;
`ifdef SPI_REG_DECODER_BURST_EN
    if (wr_q) addr_d = addr_q + 6'd1;
`endif
    if (cs_q[1]) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      sout_d  = 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = CMD;
            cnt_d   = 3'd0;
            sin_d   = 7'h00;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            sin_d = rx_byte[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              addr_d  = rx_byte[5:0];
              rw_d    = rx_byte[7];
              rd_d    = ~rx_byte[7];
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            sin_d = rx_byte[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (rw_q) begin
                dw_d = rx_byte;
                wr_d = 1'b1;
              end
`ifdef SPI_REG_DECODER_BURST_EN
              else begin
                rd_d   = 1'b1;
                addr_d = addr_q + 6'd1;
              end
`else
              state_d = IGN;
`endif
            end
          // the fall closing a byte's last bit keeps the fresh load
          end else if (sclk_fall && cnt_q != 3'd0) begin
            sout_d = {sout_q[6:0], 1'b0};
          end
        end
        IGN: begin
          state_d = IGN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sin_q   <= 7'h00;
      sout_q  <= 8'h00;
      rw_q    <= 1'b0;
      addr_q  <= 6'h00;
      dw_q    <= 8'h00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sin_q   <= sin_d;
      sout_q  <= sout_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      dw_q    <= dw_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign read       = rd_q;
  assign write      = wr_q;
  assign addr       = addr_q;
  assign data_write = dw_q;
  assign miso       = (state_q == DATA) & sout_q[7];

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Bench for spi_reg_decoder: directed table, corner sequences, random frames.
// Honours SPI_REG_DECODER_BURST_EN to select the expected frame behaviour.
module tb_spi_reg_decoder;

`ifdef SPI_REG_DECODER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_n, sclk, cs_n, mosi;
  logic       miso, read, write;
  logic [5:0] addr;
  logic [7:0] data_write, data_read;
  logic [7:0] mem [64];

  always #5 clk = ~clk;
  assign data_read = mem[addr];

  spi_reg_decoder dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .read(read), .write(write),
    .addr(addr), .data_write(data_write), .data_read(data_read)
  );

  typedef struct packed {
    logic       w;
    logic [5:0] a;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    logic [7:0] b0, b1;
    logic       exp_w;
    logic [5:0] exp_a;
    logic [7:0] exp_d;
  } vec_t;

  ev_t got[$], exp[$];
  int checks = 0, passes = 0, overlap = 0;
  logic [7:0] tx [8], rx [8];
  logic [5:0] hold_a = 6'h00;
  logic [7:0] hold_d = 8'h00;
  vec_t tbl [6];

  always @(negedge clk) begin
    if (read && write) overlap++;
    if (read === 1'b1) got.push_back('{1'b0, addr, 8'h00});
    if (write === 1'b1) got.push_back('{1'b1, addr, data_write});
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  // Frame-level reference: which accesses a frame of full bytes implies.
  task automatic model(input int nbits, input bit rst_mid);
    int full, nacc;
    logic [5:0] a, ak;
    logic w;
    logic [7:0] em;
    if (rst_mid) begin
      hold_a = 6'h00;
      hold_d = 8'h00;
      return;
    end
    full = nbits / 8;
    if (full == 0) return;
    a = tx[0][5:0];
    w = tx[0][7];
    if (BURST) nacc = w ? full - 1 : full;
    else nacc = w ? (full >= 2 ? 1 : 0) : 1;
    for (int k = 0; k < nacc; k++) begin
      ak = a + 6'(k);
      if (w) begin
        exp.push_back('{1'b1, ak, tx[k+1]});
        hold_d = tx[k+1];
      end else begin
        exp.push_back('{1'b0, ak, 8'h00});
      end
    end
    hold_a = BURST ? a + 6'(full - 1) : a;
    if (!w) begin
      for (int k = 1; k < full; k++) begin
        ak = a + 6'(k - 1);
        em = BURST ? mem[ak] : (k == 1 ? mem[a] : 8'h00);
        chk($sformatf("miso_byte%0d", k), rx[k], em);
      end
    end
  endtask

  task automatic send(input int nbits, input int gap, input bit rst_mid);
    for (int i = 0; i < 8; i++) rx[i] = 8'h00;
    cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[i/8][7-(i%8)];
      repeat (H) @(negedge clk);
      sclk = 1'b1;
      rx[i/8][7-(i%8)] = miso;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (H) @(negedge clk);
    if (rst_mid) begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid_regs", {addr, data_write}, 14'h0);
      chk("rst_mid_strb", {read, write, miso}, 3'b000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (gap) @(negedge clk);
    model(nbits, rst_mid);
  endtask

  task automatic check_log(input string nm);
    int n;
    repeat (4) @(negedge clk);
    chk({nm, "_count"}, got.size(), exp.size());
    n = got.size() < exp.size() ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_ev%0d", nm, i), got[i], exp[i]);
    chk({nm, "_addr"}, addr, hold_a);
    chk({nm, "_wdata"}, data_write, hold_d);
    got.delete();
    exp.delete();
  endtask

  initial begin
    int nb;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[6'h0A] = 8'h5C;
    mem[6'h3F] = 8'hA5;
    mem[6'h20] = 8'h81;
    tbl[0] = '{8'h81, 8'hAB, 1'b1, 6'h01, 8'hAB};
    tbl[1] = '{8'h0A, 8'hE7, 1'b0, 6'h0A, 8'h5C};
    tbl[2] = '{8'hC5, 8'h3C, 1'b1, 6'h05, 8'h3C};
    tbl[3] = '{8'h7F, 8'h00, 1'b0, 6'h3F, 8'hA5};
    tbl[4] = '{8'h80, 8'hFF, 1'b1, 6'h00, 8'hFF};
    tbl[5] = '{8'h20, 8'h18, 1'b0, 6'h20, 8'h81};

    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_regs", {addr, data_write}, 14'h0);
    chk("reset_strb", {read, write, miso}, 3'b000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      tx[0] = tbl[v].b0;
      tx[1] = tbl[v].b1;
      send(16, 8, 1'b0);
      chk($sformatf("tbl%0d_first", v), got.size() > 0 ? got[0] : '0,
          {tbl[v].exp_w, tbl[v].exp_a, tbl[v].exp_w ? tbl[v].exp_d : 8'h00});
      if (!tbl[v].exp_w) chk($sformatf("tbl%0d_miso", v), rx[1], tbl[v].exp_d);
      check_log($sformatf("tbl%0d", v));
    end

    tx[0] = 8'h82; tx[1] = 8'h33;
    send(12, 8, 1'b0);
    check_log("abort");
    send(16, 8, 1'b0);
    chk("abort_follow", {addr, data_write}, {6'h02, 8'h33});
    check_log("after_abort");

    tx[0] = 8'h84; tx[1] = 8'h77;
    send(10, 8, 1'b1);
    check_log("rst_mid");
    send(16, 8, 1'b0);
    check_log("after_rst");

    tx[0] = 8'hBF; tx[1] = 8'h11; tx[2] = 8'h22;
    send(24, 8, 1'b0);
`ifdef SPI_REG_DECODER_BURST_EN
    chk("burst_n", got.size(), 2);
    chk("burst_wrap", got.size() > 1 ? got[1] : '0, {1'b1, 6'h00, 8'h22});
`else
    chk("burst_n", got.size(), 1);
    chk("burst_first", got.size() > 0 ? got[0] : '0, {1'b1, 6'h3F, 8'h11});
`endif
    check_log("burst");

    tx[0] = 8'h0A; tx[1] = 8'h00;
    send(16, 4, 1'b0);
    tx[0] = 8'h82; tx[1] = 8'h55;
    send(16, 8, 1'b0);
    check_log("b2b");

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
      case ($urandom_range(0, 4))
        0: nb = 8;
        1: nb = 16;
        2: nb = 24;
        3: nb = 32;
        default: nb = $urandom_range(1, 31);
      endcase
      send(nb, 4 + $urandom_range(0, 6), 1'b0);
      check_log($sformatf("rnd%0d", f));
    end

    chk("no_overlap", overlap, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
